// File: rtl/controlador_pkg.sv
// Shared definitions for the digit-entry interface: FSM encoding,
// digit width, default code and the digit extraction helper.
package controlador_pkg;

    localparam int DIGIT_W = 4;
    localparam int STATE_W = 3;

    // Default code 5,8,9,2,0,4 (digit 0 in the most significant nibble used)
    localparam logic [23:0] CODIGO_PADRAO = 24'h589204;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_GAP  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } estado_t;

    // Digit idx of an n-digit code; digit 0 sits in the highest used nibble.
    // Values above 9 are returned unchanged so rejection paths can be exercised.
    function automatic logic [DIGIT_W-1:0] digito_de(
        input logic [31:0] codigo,
        input int          n_digitos,
        input logic [2:0]  idx
    );
        return DIGIT_W'(codigo >> (DIGIT_W * (n_digitos - 1 - int'(idx))));
    endfunction

endpackage

// File: rtl/emissor_codigo_contador_espera.sv
// Loadable down-counter with a terminal flag. Saturates at zero so a
// wait state never wraps around while it is being held.
module contador_espera #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         carga,
    input  logic [W-1:0] valor,
    input  logic         habilita,
    output logic         terminal
);

    logic [W-1:0] cont_d;
    logic [W-1:0] cont_q;

    // Next count: load has priority, otherwise decrement towards zero
    always_comb begin
        cont_d = cont_q;
        if (carga) begin
            cont_d = valor;
        end else if (habilita && (cont_q != {W{1'b0}})) begin
            cont_d = cont_q - W'(1);
        end else begin
            cont_d = cont_q;
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cont_q <= {W{1'b0}};
        end else begin
            cont_q <= cont_d;
        end
    end

    assign terminal = (cont_q == {W{1'b0}});

endmodule

// File: rtl/emissor_codigo.sv
// Code emitter: sends a stored N-digit code as insere/numero beats with a
// programmable gap, then waits a bounded time for led_in and reports.
module emissor_codigo
    import controlador_pkg::*;
#(
    parameter int          N_DIGITS = 6,
    parameter logic [31:0] CODE     = {8'h00, CODIGO_PADRAO},
    parameter int          GAP      = 1,
    parameter int          TIMEOUT  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               led_in,
    output logic [DIGIT_W-1:0] numero,
    output logic               insere,
    output logic [2:0]         digito_idx,
    output logic               busy,
    output logic               done,
    output logic               sucesso
);

    localparam logic [2:0] ULTIMO    = 3'(N_DIGITS - 1);
    localparam int         GAP_M1    = (GAP > 0) ? (GAP - 1) : 0;
    localparam logic [3:0] GAP_CARGA = 4'(GAP_M1);
    localparam logic [7:0] TO_CARGA  = 8'(TIMEOUT - 1);

    estado_t            estado_d,  estado_q;
    logic [2:0]         idx_d,     idx_q;
    logic [DIGIT_W-1:0] numero_d,  numero_q;
    logic               insere_d,  insere_q;
    logic               busy_d,    busy_q;
    logic               done_d,    done_q;
    logic               sucesso_d, sucesso_q;

    logic gap_carga_s, gap_fim_s;
    logic to_carga_s,  to_fim_s;

    contador_espera #(.W(4)) u_gap (
        .clk      (clk),
        .reset    (reset),
        .carga    (gap_carga_s),
        .valor    (GAP_CARGA),
        .habilita (estado_q == ST_GAP),
        .terminal (gap_fim_s)
    );

    contador_espera #(.W(8)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .carga    (to_carga_s),
        .valor    (TO_CARGA),
        .habilita (estado_q == ST_WAIT),
        .terminal (to_fim_s)
    );

    // Next state and next registered outputs; abort beats led_in and timeout
    always_comb begin
        estado_d    = estado_q;
        idx_d       = idx_q;
        numero_d    = numero_q;
        insere_d    = 1'b0;
        done_d      = 1'b0;
        sucesso_d   = sucesso_q;
        gap_carga_s = 1'b0;
        to_carga_s  = 1'b0;
        case (estado_q)
            ST_IDLE: begin
                if (start) begin
                    estado_d  = ST_SEND;
                    idx_d     = 3'd0;
                    numero_d  = digito_de(CODE, N_DIGITS, 3'd0);
                    insere_d  = 1'b1;
                    sucesso_d = 1'b0;
                end else begin
                    estado_d  = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    estado_d  = ST_IDLE;
                    sucesso_d = 1'b0;
                end else if (idx_q == ULTIMO) begin
                    estado_d   = ST_WAIT;
                    to_carga_s = 1'b1;
                end else if (GAP > 0) begin
                    estado_d    = ST_GAP;
                    gap_carga_s = 1'b1;
                end else begin
                    estado_d = ST_SEND;
                    idx_d    = idx_q + 3'd1;
                    numero_d = digito_de(CODE, N_DIGITS, idx_q + 3'd1);
                    insere_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    estado_d  = ST_IDLE;
                    sucesso_d = 1'b0;
                end else if (gap_fim_s) begin
                    estado_d = ST_SEND;
                    idx_d    = idx_q + 3'd1;
                    numero_d = digito_de(CODE, N_DIGITS, idx_q + 3'd1);
                    insere_d = 1'b1;
                end else begin
                    estado_d = ST_GAP;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    estado_d  = ST_IDLE;
                    sucesso_d = 1'b0;
                end else if (led_in) begin
                    estado_d  = ST_DONE;
                    done_d    = 1'b1;
                    sucesso_d = 1'b1;
                end else if (to_fim_s) begin
                    estado_d  = ST_DONE;
                    done_d    = 1'b1;
                    sucesso_d = 1'b0;
                end else begin
                    estado_d  = ST_WAIT;
                end
            end
            ST_DONE: begin
                estado_d = ST_IDLE;
            end
            default: begin
                estado_d  = ST_IDLE;
                sucesso_d = 1'b0;
            end
        endcase
    end

    assign busy_d = (estado_d != ST_IDLE);

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_q  <= ST_IDLE;
            idx_q     <= 3'd0;
            numero_q  <= {DIGIT_W{1'b0}};
            insere_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sucesso_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            idx_q     <= idx_d;
            numero_q  <= numero_d;
            insere_q  <= insere_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sucesso_q <= sucesso_d;
        end
    end

    assign numero     = numero_q;
    assign insere     = insere_q;
    assign digito_idx = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sucesso    = sucesso_q;

endmodule

// File: tb/tb_emissor_codigo.sv
// Testbench for emissor_codigo: a table of per-cycle vectors for the default
// configuration plus hand-written sequences for abort, reset and GAP=0.
module tb_emissor_codigo;

    logic clk = 1'b0;
    logic reset, start, abort, led_in, start_b;

    logic [3:0] numero,  numero_b;
    logic       insere,  insere_b;
    logic [2:0] idx,     idx_b;
    logic       busy,    busy_b;
    logic       done,    done_b;
    logic       sucesso, sucesso_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       st, ab, led, ins;
        logic [3:0] num;
        logic [2:0] idx;
        logic       busy, done, suc;
    } vec_t;

    vec_t tbl[$];
    int   dig [6];
    int   dig_b [6];

    always #5 clk = ~clk;

    emissor_codigo dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .led_in(led_in),
        .numero(numero), .insere(insere), .digito_idx(idx), .busy(busy),
        .done(done), .sucesso(sucesso)
    );

    emissor_codigo #(.GAP(0), .CODE(32'h005A0000)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort), .led_in(led_in),
        .numero(numero_b), .insere(insere_b), .digito_idx(idx_b), .busy(busy_b),
        .done(done_b), .sucesso(sucesso_b)
    );

    function automatic vec_t v(input int st, ab, led, ins, num, ix, bz, dn, sc);
        vec_t r;
        r.st = (st != 0); r.ab = (ab != 0); r.led = (led != 0); r.ins = (ins != 0);
        r.num = 4'(num); r.idx = 3'(ix);
        r.busy = (bz != 0); r.done = (dn != 0); r.suc = (sc != 0);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_main(input string tag, input int ins, num, ix, bz, dn, sc);
        chk({tag, " insere"},  32'(insere),  32'(ins));
        chk({tag, " numero"},  32'(numero),  32'(num));
        chk({tag, " idx"},     32'(idx),     32'(ix));
        chk({tag, " busy"},    32'(busy),    32'(bz));
        chk({tag, " done"},    32'(done),    32'(dn));
        chk({tag, " sucesso"}, 32'(sucesso), 32'(sc));
    endtask

    // Drive inputs, let one rising edge pass, then sample just after it
    task automatic step(input logic s, input logic a, input logic l);
        start = s; abort = a; led_in = l;
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected normal end");
        $fatal(1);
    end

    initial begin
        dig   = '{5, 8, 9, 2, 0, 4};
        dig_b = '{5, 10, 0, 0, 0, 0};

        // Full send with timeout: beats at k+1..k+11, done at k+20
        for (int i = 0; i < 6; i++) begin
            tbl.push_back(v((i == 0) ? 1 : 0, 0, 0, 1, dig[i], i, 1, 0, 0));
            if (i < 5) tbl.push_back(v(0, 0, 0, 0, dig[i], i, 1, 0, 0));
        end
        for (int i = 0; i < 8; i++) tbl.push_back(v(0, 0, 0, 0, 4, 5, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 4, 5, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 4, 5, 0, 0, 0));
        // Success: led_in during k+13, done at k+14; start held through DONE
        for (int i = 0; i < 6; i++) begin
            tbl.push_back(v((i == 0) ? 1 : 0, 0, 0, 1, dig[i], i, 1, 0, 0));
            if (i < 5) tbl.push_back(v(0, 0, 0, 0, dig[i], i, 1, 0, 0));
        end
        tbl.push_back(v(0, 0, 0, 0, 4, 5, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 4, 5, 1, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 4, 5, 1, 1, 1));
        tbl.push_back(v(1, 0, 0, 0, 4, 5, 0, 0, 1));
        tbl.push_back(v(1, 0, 0, 1, 5, 0, 1, 0, 0));
        // Abort during k+4 (GAP) -> idle at k+5, no done, sucesso 0
        tbl.push_back(v(0, 0, 0, 0, 5, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 8, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 8, 1, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 8, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 8, 1, 0, 0, 0));

        // Reset held two cycles with start high
        reset = 1'b0; start_b = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk_main("reset", 0, 0, 0, 0, 0, 0);
        chk("reset busy_b",   32'(busy_b),   32'd0);
        chk("reset insere_b", 32'(insere_b), 32'd0);
        chk("reset numero_b", 32'(numero_b), 32'd0);
        reset = 1'b1; start_b = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk_main("idle", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].st, tbl[i].ab, tbl[i].led);
            chk_main($sformatf("tbl%0d", i), 32'(tbl[i].ins), 32'(tbl[i].num),
                     32'(tbl[i].idx), 32'(tbl[i].busy), 32'(tbl[i].done), 32'(tbl[i].suc));
        end

        // Start while busy is ignored; abort beats led_in in WAIT
        step(1'b1, 1'b0, 1'b0);
        for (int n = 2; n <= 6; n++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk_main("busy_start k+7", 1, 2, 3, 1, 0, 0);
        for (int n = 8; n <= 13; n++) step(1'b0, 1'b0, 1'b0);
        chk_main("wait k+13", 0, 4, 5, 1, 0, 0);
        step(1'b0, 1'b1, 1'b1);
        chk_main("abort_vs_led", 0, 4, 5, 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b0, 1'b0);
            chk($sformatf("post_abort%0d done", n), 32'(done), 32'd0);
        end

        // Reset in the middle of WAIT
        step(1'b1, 1'b0, 1'b0);
        for (int n = 2; n <= 14; n++) step(1'b0, 1'b0, 1'b0);
        chk("mid_wait busy", 32'(busy), 32'd1);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk_main("mid_wait reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step(1'b0, 1'b0, 1'b0);
            chk($sformatf("post_reset%0d done", n), 32'(done), 32'd0);
            chk($sformatf("post_reset%0d busy", n), 32'(busy), 32'd0);
        end

        // GAP=0, code 5,10,0,0,0,0: six back-to-back beats
        start_b = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        start_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step(1'b0, 1'b0, 1'b0);
            chk($sformatf("gap0 beat%0d insere", i), 32'(insere_b), 32'd1);
            chk($sformatf("gap0 beat%0d numero", i), 32'(numero_b), 32'(dig_b[i]));
            chk($sformatf("gap0 beat%0d idx", i),    32'(idx_b),    32'(i));
        end
        for (int n = 0; n < 8; n++) begin
            step(1'b0, 1'b0, 1'b0);
            chk($sformatf("gap0 wait%0d insere", n), 32'(insere_b), 32'd0);
            chk($sformatf("gap0 wait%0d done", n),   32'(done_b),   32'd0);
            chk($sformatf("gap0 wait%0d busy", n),   32'(busy_b),   32'd1);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("gap0 done",    32'(done_b),    32'd1);
        chk("gap0 sucesso", 32'(sucesso_b), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("gap0 idle busy", 32'(busy_b), 32'd0);
        chk("gap0 idle done", 32'(done_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
